mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store initiator that sits between the execute stage and the word-addressed data RAM.
- Converts byte/halfword/word load and store requests into word-wide RAM accesses.
- Sub-word stores are performed as read-modify-write, because the RAM only writes whole words.
- Supplies aligned, sign- or zero-extended load data back to the core, plus a one-cycle completion pulse.

Parameters:
- MEM_NUM, 4096: RAM depth in 32-bit words. Any word index >= MEM_NUM is an access error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_i  in  1  request strobe; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is an error.
- unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: error, no RAM write performed.
- rdata_o  out  32  load result; valid from done_o onward, held until the next load completes.
- ram_addr_o  out  32  byte address to RAM; the RAM uses bits [31:2].
- ram_we_o  out  1  RAM write enable.
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data; combinational from ram_addr_o.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - busy_o, done_o, err_o, ram_we_o = 0.
  - rdata_o, ram_addr_o, ram_data_o, and all latched request fields = 0.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE:
  - If req_i = 1, latch we_i, size_i, unsigned_i, addr_i and wdata_i, then go to:
    - RESP with err = 1 if size_i = 11, if addr_i[31:2] >= MEM_NUM, or if misaligned (see Optional Feature);
    - else RD for a load;
    - else WR for a word store;
    - else RMW_RD for a byte/half store.
  - If req_i = 0, stay in IDLE.
- RD:
  - Drive ram_addr_o = {addr[31:2], 2'b00}.
  - Extract lane: byte selected by addr[1:0], half selected by addr[1].
  - Extend per unsigned_i and register the result into rdata_o.
  - Go to RESP.
- RMW_RD: drive the word address, capture ram_data_i into merge_q, go to WR.
- WR:
  - ram_we_o = 1 for exactly this cycle; ram_addr_o = word address.
  - Word store: ram_data_o = wdata.
  - Sub-word store: ram_data_o = merge_q with the selected byte/half lane replaced by wdata[7:0] / wdata[15:0]; all other lanes unchanged.
  - Go to RESP.
- RESP: done_o = 1, err_o = latched err, go to IDLE.
- Latency from the accept cycle (cycle 0):
  - Error: done_o in cycle 1.
  - Load: done_o in cycle 2.
  - Word store: done_o in cycle 2.
  - Sub-word store: done_o in cycle 3.
- busy_o is high in RD, RMW_RD, WR and RESP.
- req_i is ignored outside IDLE. A back-to-back request is accepted at the earliest in the cycle after RESP.
- Outside WR, ram_we_o = 0 and ram_data_o holds its last value.
- Error requests never assert ram_we_o and leave rdata_o unchanged.
- Reset mid-operation: aborts immediately. A WR in progress is not issued after reset deasserts.

Optional Feature:
- Macro: MEM_LSU_ALIGN_CHECK_EN.
- Defined:
  - Half with addr[0] = 1 is an error.
  - Word with addr[1:0] != 00 is an error.
  - Error timing as above.
- Undefined:
  - No alignment error.
  - Offending low bits are ignored: half uses addr[1], word uses lane 0.
  - Range and size=11 errors remain.

Decomposition:
- Shared defines.v (existing):
  - reuse MemAddrBus, MemBus, ZeroWord, WriteEnable;
  - add LSU_SIZE_B/H/W codes;
  - add state encodings LSU_IDLE/RD/RMW_RD/WR/RESP.
- Sub-module mem_lsu_lane, purely combinational:
  - load path: extract + extend from (word, addr[1:0], size, unsigned);
  - store path: merge from (old word, wdata, addr[1:0], size).
- The FSM stays in mem_lsu.

Test Plan:
1. Word store then load: store addr 0x10, data 0xDEADBEEF.
   - Expect ram_we_o in cycle 1 and done_o in cycle 2.
   - A load word from 0x10 then returns rdata_o = 0xDEADBEEF with done_o in cycle 2.
2. Byte RMW: RAM[0x10] = 0xDEADBEEF; store byte 0xA5 to 0x12.
   - Expect the RAM write of 0xDEA5BEEF in cycle 2 and done_o in cycle 3.
3. Sign extension:
   - Load byte signed from 0x13 -> 0xFFFFFFDE.
   - Load byte unsigned from 0x13 -> 0x000000DE.
   - Load half signed from 0x10 -> 0xFFFFBEEF.
4. Errors:
   - Word at addr = MEM_NUM*4 -> done_o + err_o in cycle 1, no ram_we_o.
   - size_i = 11 -> same response.
   - Half at 0x11 -> err with MEM_LSU_ALIGN_CHECK_EN defined; a normal access of the 0x10 half without it.
5. Busy/ignore: assert req_i continuously.
   - Requests during busy are not accepted.
   - A second request is accepted the cycle after RESP.
   - Exactly one done_o per accepted request.
6. Reset mid-RMW: drop rst while in RMW_RD.
   - Outputs are zero immediately.
   - No ram_we_o after release; the RAM word is unchanged.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared bus widths, access-size codes and FSM state encoding
// for the load/store unit.
package mem_lsu_pkg;

  localparam int               MemAddrBus  = 32;
  localparam int               MemBus      = 32;
  localparam logic [MemBus-1:0] ZeroWord    = '0;
  localparam logic             WriteEnable = 1'b1;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_RD     = 3'd1,
    LSU_RMW_RD = 3'd2,
    LSU_WR     = 3'd3,
    LSU_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: combinational byte-lane logic for the load/store unit.
// Load path extracts and extends a byte/half/word from a RAM word.
// Store path merges store data into an old RAM word.
// For a half access, only offset bit 1 picks the lane.
// For a word access, the offset is ignored.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [MemBus-1:0] load_word_i,
  input  logic [MemBus-1:0] old_word_i,
  input  logic [MemBus-1:0] wdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [MemBus-1:0] load_data_o,
  output logic [MemBus-1:0] merge_data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Select the addressed byte and half lanes of the read word
  always_comb begin
    byteSel = load_word_i[7:0];
    case (offset_i)
      2'd0:    byteSel = load_word_i[7:0];
      2'd1:    byteSel = load_word_i[15:8];
      2'd2:    byteSel = load_word_i[23:16];
      default: byteSel = load_word_i[31:24];
    endcase
    halfSel = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];
  end

  // Right-justify the selected lane and sign- or zero-extend it
  always_comb begin
    load_data_o = load_word_i;
    case (size_i)
      LSU_SIZE_B: load_data_o = {{24{~unsigned_i & byteSel[7]}}, byteSel};
      LSU_SIZE_H: load_data_o = {{16{~unsigned_i & halfSel[15]}}, halfSel};
      default:    load_data_o = load_word_i;
    endcase
  end

  // Overlay the store data onto the addressed lane and keep the other lanes
  always_comb begin
    merge_data_o = old_word_i;
    case (size_i)
      LSU_SIZE_B: begin
        case (offset_i)
          2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_data_o[23:16] = wdata_i[7:0];
          default: merge_data_o[31:24] = wdata_i[7:0];
        endcase
      end
      LSU_SIZE_H: begin
        if (offset_i[1]) merge_data_o[31:16] = wdata_i[15:0];
        else             merge_data_o[15:0]  = wdata_i[15:0];
      end
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator between the execute stage and a word-addressed RAM.
// Sub-word stores use read-modify-write.
// Build option MEM_LSU_ALIGN_CHECK_EN: misaligned half/word accesses are errors.
// Without it, the low address bits beyond the lane granularity are ignored.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int MEM_NUM = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [MemAddrBus-1:0] addr_i,
  input  logic [MemBus-1:0]     wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [MemBus-1:0]     rdata_o,
  output logic [MemAddrBus-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [MemBus-1:0]     ram_data_o,
  input  logic [MemBus-1:0]     ram_data_i
);

  lsu_state_e state_q, state_d;

  logic                  reqWe_q;
  logic [1:0]            reqSize_q;
  logic                  reqUnsigned_q;
  logic [MemAddrBus-1:0] reqAddr_q;
  logic [MemBus-1:0]     reqWdata_q;
  logic                  reqErr_q;
  logic [MemBus-1:0]     merge_q;
  logic [MemBus-1:0]     rdata_q;
  logic [MemBus-1:0]     ramData_q;

  logic              sizeBad, rangeBad, alignBad, reqBad;
  logic              accept;
  logic [MemBus-1:0] loadData;
  logic [MemBus-1:0] storeData;

  // Classify an incoming request as erroneous before it is latched
  always_comb begin
    sizeBad  = (size_i == 2'b11);
    rangeBad = (addr_i[31:2] >= 30'(MEM_NUM));
`ifdef MEM_LSU_ALIGN_CHECK_EN
    alignBad = ((size_i == LSU_SIZE_H) && addr_i[0]) ||
               ((size_i == LSU_SIZE_W) && (addr_i[1:0] != 2'b00));
`else
    alignBad = 1'b0;
`endif
    reqBad   = sizeBad | rangeBad | alignBad;
    accept   = (state_q == LSU_IDLE) && req_i;
  end

  mem_lsu_lane u_lane (
    .load_word_i  (ram_data_i),
    .old_word_i   (merge_q),
    .wdata_i      (reqWdata_q),
    .offset_i     (reqAddr_q[1:0]),
    .size_i       (reqSize_q),
    .unsigned_i   (reqUnsigned_q),
    .load_data_o  (loadData),
    .merge_data_o (storeData)
  );

  assign ram_addr_o = {reqAddr_q[31:2], 2'b00};
  assign rdata_o    = rdata_q;

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_d;
  end

  // Latch the request fields and its error verdict when a request is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqWe_q       <= 1'b0;
      reqSize_q     <= 2'b00;
      reqUnsigned_q <= 1'b0;
      reqAddr_q     <= ZeroWord;
      reqWdata_q    <= ZeroWord;
      reqErr_q      <= 1'b0;
    end else if (accept) begin
      reqWe_q       <= we_i;
      reqSize_q     <= size_i;
      reqUnsigned_q <= unsigned_i;
      reqAddr_q     <= addr_i;
      reqWdata_q    <= wdata_i;
      reqErr_q      <= reqBad;
    end
  end

  // Datapath registers: RMW old word, load result and last RAM write data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merge_q   <= ZeroWord;
      rdata_q   <= ZeroWord;
      ramData_q <= ZeroWord;
    end else begin
      if (state_q == LSU_RMW_RD)           merge_q   <= ram_data_i;
      if (state_q == LSU_RD && !reqWe_q)   rdata_q   <= loadData;
      if (state_q == LSU_WR)               ramData_q <= storeData;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    busy_o     = (state_q != LSU_IDLE);
    done_o     = 1'b0;
    err_o      = 1'b0;
    ram_we_o   = 1'b0;
    ram_data_o = ramData_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_i) begin
          if (reqBad)                  state_d = LSU_RESP;
          else if (!we_i)              state_d = LSU_RD;
          else if (size_i == LSU_SIZE_W) state_d = LSU_WR;
          else                         state_d = LSU_RMW_RD;
        end
      end
      LSU_RD:     state_d = LSU_RESP;
      LSU_RMW_RD: state_d = LSU_WR;
      LSU_WR: begin
        ram_we_o   = reqWe_q ? WriteEnable : 1'b0;
        ram_data_o = storeData;
        state_d    = LSU_RESP;
      end
      LSU_RESP: begin
        done_o  = 1'b1;
        err_o   = reqErr_q;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven self-checking bench for mem_lsu with a scoreboard queue
// and a behavioural word RAM; plus hand sequences for busy/ignore and mid-RMW reset.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int MemNum = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata, ramAddr, ramDataOut, ramDataIn;
  logic        ramWe;
  logic        ramInit;

  logic [31:0] ram [0:MemNum-1];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    int          expDone;
    int          expWeCyc;
    logic [31:0] expWeData;
    logic        chkRdata;
    logic [31:0] expRdata;
  } vec_t;

  localparam int NumVec = 17;
  vec_t vecs [NumVec];
  vec_t sbQ [$];

  int checks = 0;
  int errors = 0;

  mem_lsu #(.MEM_NUM(MemNum)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .rdata_o    (rdata),
    .ram_addr_o (ramAddr),
    .ram_we_o   (ramWe),
    .ram_data_o (ramDataOut),
    .ram_data_i (ramDataIn)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on the clock edge
  assign ramDataIn = ram[ramAddr[13:2]];
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < MemNum; i++) ram[i] <= 32'h0;
    end else if (ramWe) begin
      ram[ramAddr[13:2]] <= ramDataOut;
    end
  end

  task automatic checkValue(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vWe, input logic [1:0] vSize, input logic vUns,
                              input logic [31:0] vAddr, input logic [31:0] vWdata,
                              input logic vErr, input int vDone, input int vWeCyc,
                              input logic [31:0] vWeData, input logic vChk,
                              input logic [31:0] vRd);
    vec_t v;
    v.we = vWe; v.size = vSize; v.uns = vUns; v.addr = vAddr; v.wdata = vWdata;
    v.expErr = vErr; v.expDone = vDone; v.expWeCyc = vWeCyc; v.expWeData = vWeData;
    v.chkRdata = vChk; v.expRdata = vRd;
    return v;
  endfunction

  // Pop the expected record for a completed request and compare what was observed
  task automatic checkOutput(input int idx, input int doneCyc, input logic gotErr,
                             input int weCyc, input int weCnt, input logic [31:0] weData,
                             input logic [31:0] gotRdata, input logic [31:0] heldData);
    vec_t e;
    if (sbQ.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL vec%0d scoreboard: got empty queue expected an entry", idx);
      return;
    end
    e = sbQ.pop_front();
    checkValue($sformatf("vec%0d done cycle", idx), doneCyc, e.expDone);
    if (doneCyc == 0) return;
    checkValue($sformatf("vec%0d err", idx), {31'b0, gotErr}, {31'b0, e.expErr});
    checkValue($sformatf("vec%0d ram_we count", idx), weCnt, (e.expWeCyc != 0) ? 1 : 0);
    if (e.expWeCyc != 0) begin
      checkValue($sformatf("vec%0d ram_we cycle", idx), weCyc, e.expWeCyc);
      checkValue($sformatf("vec%0d ram write data", idx), weData, e.expWeData);
      checkValue($sformatf("vec%0d ram_data held", idx), heldData, e.expWeData);
    end
    if (e.chkRdata) checkValue($sformatf("vec%0d rdata", idx), gotRdata, e.expRdata);
  endtask

  // Drive one request for one cycle, push its expectation and watch it complete
  task automatic applyStimulus(input int idx, input vec_t v);
    int doneCyc, weCyc, weCnt;
    logic gotErr;
    logic [31:0] weData, gotRdata, heldData;
    doneCyc = 0; weCyc = 0; weCnt = 0; gotErr = 1'b0;
    weData = 32'h0; gotRdata = 32'h0; heldData = 32'h0;
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
    sbQ.push_back(v);
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 8 && doneCyc == 0; c++) begin
      @(negedge clk);
      if (ramWe) begin
        weCnt++;
        if (weCyc == 0) begin weCyc = c; weData = ramDataOut; end
      end
      if (done) begin
        doneCyc = c; gotErr = err; gotRdata = rdata; heldData = ramDataOut;
      end
    end
    checkOutput(idx, doneCyc, gotErr, weCyc, weCnt, weData, gotRdata, heldData);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCnt, firstDone, secondDone, weSeen;
    logic busyC3;

    rst = 1'b0; ramInit = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;

    vecs[0]  = mk(1, LSU_SIZE_W, 0, 32'h10, 32'hDEADBEEF, 0, 2, 1, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, LSU_SIZE_W, 0, 32'h10, 32'h0, 0, 2, 0, 0, 1, 32'hDEADBEEF);
    vecs[2]  = mk(1, LSU_SIZE_B, 0, 32'h12, 32'h123456A5, 0, 3, 2, 32'hDEA5BEEF, 0, 0);
    vecs[3]  = mk(0, LSU_SIZE_B, 0, 32'h13, 32'h0, 0, 2, 0, 0, 1, 32'hFFFFFFDE);
    vecs[4]  = mk(0, LSU_SIZE_B, 1, 32'h13, 32'h0, 0, 2, 0, 0, 1, 32'h000000DE);
    vecs[5]  = mk(0, LSU_SIZE_H, 0, 32'h10, 32'h0, 0, 2, 0, 0, 1, 32'hFFFFBEEF);
    vecs[6]  = mk(0, LSU_SIZE_B, 0, 32'h12, 32'h0, 0, 2, 0, 0, 1, 32'hFFFFFFA5);
    vecs[7]  = mk(0, LSU_SIZE_W, 0, MemNum * 4, 32'h0, 1, 1, 0, 0, 1, 32'hFFFFFFA5);
    vecs[8]  = mk(1, 2'b11, 0, 32'h10, 32'h0, 1, 1, 0, 0, 1, 32'hFFFFFFA5);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    vecs[9]  = mk(0, LSU_SIZE_H, 1, 32'h11, 32'h0, 1, 1, 0, 0, 1, 32'hFFFFFFA5);
`else
    vecs[9]  = mk(0, LSU_SIZE_H, 1, 32'h11, 32'h0, 0, 2, 0, 0, 1, 32'h0000BEEF);
`endif
    vecs[10] = mk(1, LSU_SIZE_H, 0, 32'h16, 32'h0000CAFE, 0, 3, 2, 32'hCAFE0000, 0, 0);
    vecs[11] = mk(0, LSU_SIZE_W, 0, 32'h14, 32'h0, 0, 2, 0, 0, 1, 32'hCAFE0000);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    vecs[12] = mk(1, LSU_SIZE_W, 0, 32'h1A, 32'h11223344, 1, 1, 0, 0, 0, 0);
    vecs[13] = mk(0, LSU_SIZE_W, 0, 32'h18, 32'h0, 0, 2, 0, 0, 1, 32'h00000000);
`else
    vecs[12] = mk(1, LSU_SIZE_W, 0, 32'h1A, 32'h11223344, 0, 2, 1, 32'h11223344, 0, 0);
    vecs[13] = mk(0, LSU_SIZE_W, 0, 32'h18, 32'h0, 0, 2, 0, 0, 1, 32'h11223344);
`endif
    vecs[14] = mk(0, LSU_SIZE_H, 0, 32'h16, 32'h0, 0, 2, 0, 0, 1, 32'hFFFFCAFE);
    vecs[15] = mk(1, LSU_SIZE_B, 0, (MemNum - 1) * 4 + 1, 32'h0000005A, 0, 3, 2, 32'h00005A00, 0, 0);
    vecs[16] = mk(0, LSU_SIZE_H, 1, (MemNum - 1) * 4, 32'h0, 0, 2, 0, 0, 1, 32'h00005A00);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset ctrl", {28'b0, busy, done, err, ramWe}, 32'h0);
    checkValue("reset rdata", rdata, 32'h0);
    checkValue("reset ram_addr", ramAddr, 32'h0);
    checkValue("reset ram_data", ramDataOut, 32'h0);
    ramInit = 1'b0;
    rst = 1'b1;

    $display("[TB] running %0d table vectors", NumVec);
    for (int i = 0; i < NumVec; i++) applyStimulus(i, vecs[i]);

    // Busy/ignore: req_i held high across two back-to-back loads
    $display("[TB] back-to-back requests with req held high");
    doneCnt = 0; firstDone = 0; secondDone = 0; busyC3 = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = LSU_SIZE_W; uns = 1'b0; addr = 32'h10; wdata = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 3) busyC3 = busy;
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) firstDone = c;
        else if (doneCnt == 2) secondDone = c;
      end
      if (c == 5) req = 1'b0;
    end
    checkValue("b2b done count", doneCnt, 2);
    checkValue("b2b first done cycle", firstDone, 2);
    checkValue("b2b second done cycle", secondDone, 5);
    checkValue("b2b busy in gap cycle", {31'b0, busyC3}, 32'h0);
    checkValue("b2b rdata", rdata, 32'hDEA5BEEF);

    // Reset during RMW_RD of a byte store to word 0x14
    $display("[TB] reset during read-modify-write");
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = LSU_SIZE_B; uns = 1'b0; addr = 32'h14; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkValue("rmw busy before reset", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    checkValue("mid reset ctrl", {28'b0, busy, done, err, ramWe}, 32'h0);
    checkValue("mid reset rdata", rdata, 32'h0);
    checkValue("mid reset ram_addr", ramAddr, 32'h0);
    checkValue("mid reset ram_data", ramDataOut, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    weSeen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ramWe || done) weSeen++;
    end
    checkValue("post reset writes/dones", weSeen, 0);
    checkValue("post reset ram word", ram[5], 32'hCAFE0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
